// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two requesters share one 2-bit ALU datapath. A round-robin
//               arbiter grants one requester at a time, captures its operands,
//               runs EXEC_CYCLES execute cycles and presents a 3-bit result
//               held until that requester acknowledges it.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               req0_i / req1_i      - operation requests
//               a0_i, b0_i, sel0_i   - requester 0 operands / op select
//               a1_i, b1_i, sel1_i   - requester 1 operands / op select
//               gnt0_o / gnt1_o      - one-cycle pulse: operands captured
//               rsp_valid0_o/1_o     - result available
//               rsp_y0_o / rsp_y1_o  - 3-bit result
//               rsp_ack0_i / 1_i     - requester consumes its result
//               busy_o               - state is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic [1:0] a0_i,
   input  logic [1:0] b0_i,
   input  logic [1:0] a1_i,
   input  logic [1:0] b1_i,
   input  logic [2:0] sel0_i,
   input  logic [2:0] sel1_i,
   output logic       gnt0_o,
   output logic       gnt1_o,
   output logic       rsp_valid0_o,
   output logic       rsp_valid1_o,
   output logic [2:0] rsp_y0_o,
   output logic [2:0] rsp_y1_o,
   input  logic       rsp_ack0_i,
   input  logic       rsp_ack1_i,
   output logic       busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [1:0] c_cnt_last = 2'(EXEC_CYCLES - 1);

   state_t     state_q;
   logic [1:0] cnt_q;
   logic       win_q;      // 0: requester 0 in flight, 1: requester 1
   logic       last_q;     // requester granted most recently
   logic [1:0] a_q;
   logic [1:0] b_q;
   logic [2:0] sel_q;
   logic       gnt0_q;
   logic       gnt1_q;
   logic       rv0_q;
   logic       rv1_q;
   logic [2:0] y0_q;
   logic [2:0] y1_q;
   logic       busy_q;

   logic       win_d;
   logic [2:0] alu_y_d;

   // Requester 1 wins when it asks alone, or on a tie when requester 0
   // was the one granted last.
   assign win_d = req1_i & (~req0_i | ~last_q);

   function automatic logic [2:0] alu(input logic [1:0] a,
                                      input logic [1:0] b,
                                      input logic [2:0] sel);
      logic [2:0] ax;
      logic [2:0] bx;
      ax = {1'b0, a};
      bx = {1'b0, b};
      case (sel)
         3'b000:  alu = ax + bx;
         3'b001:  alu = ax - bx;   // wraps modulo 8
         3'b010:  alu = ax & bx;
         3'b011:  alu = ax | bx;
         3'b100:  alu = ax ^ bx;
         default: alu = 3'b000;
      endcase
   endfunction

   assign alu_y_d = alu(a_q, b_q, sel_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         win_q   <= 1'b0;
         last_q  <= 1'b1;       // requester 0 wins the first tie
         a_q     <= 2'd0;
         b_q     <= 2'd0;
         sel_q   <= 3'd0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         y0_q    <= 3'd0;
         y1_q    <= 3'd0;
         busy_q  <= 1'b0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req0_i || req1_i) begin
                  win_q   <= win_d;
                  last_q  <= win_d;
                  a_q     <= win_d ? a1_i   : a0_i;
                  b_q     <= win_d ? b1_i   : b0_i;
                  sel_q   <= win_d ? sel1_i : sel0_i;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
                  cnt_q   <= 2'd0;
                  state_q <= S_EXEC;
                  busy_q  <= 1'b1;
               end
            end
            S_EXEC: begin
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == c_cnt_last) begin
                  if (win_q) begin
                     rv1_q <= 1'b1;
                     y1_q  <= alu_y_d;
                  end else begin
                     rv0_q <= 1'b1;
                     y0_q  <= alu_y_d;
                  end
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               // Only the in-flight requester's ack completes the response.
               if (win_q ? rsp_ack1_i : rsp_ack0_i) begin
                  rv0_q   <= 1'b0;
                  rv1_q   <= 1'b0;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0_o       = gnt0_q;
   assign gnt1_o       = gnt1_q;
   assign rsp_valid0_o = rv0_q;
   assign rsp_valid1_o = rv1_q;
   assign rsp_y0_o     = y0_q;
   assign rsp_y1_o     = y1_q;
   assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter EXEC_CYCLES, default 1, giving the number of EXEC-state cycles per operation (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports req0 / req1, input, 1 bit each: requester 0/1 asks for an ALU operation.
REQ-005 The block SHALL have ports a0, b0 / a1, b1, input, 2 bits each: operands of requester 0/1.
REQ-006 The block SHALL have ports sel0 / sel1, input, 3 bits each: operation select of requester 0/1.
- 000 add
- 001 subtract
- 010 AND
- 011 OR
- 100 XOR
- others give result 0
REQ-007 The block SHALL have ports gnt0 / gnt1, output, 1 bit each: one-cycle pulse meaning that requester's operands were captured.
REQ-008 The block SHALL have ports rsp_valid0 / rsp_valid1, output, 1 bit each: result available for requester 0/1.
REQ-009 The block SHALL have ports rsp_y0 / rsp_y1, output, 3 bits each: result for requester 0/1.
REQ-010 The block SHALL have ports rsp_ack0 / rsp_ack1, input, 1 bit each: requester 0/1 consumes its result.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL share one 2-bit ALU datapath between the two requesters; at most one operation is in flight at a time.
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP; all outputs are registered.
REQ-014 IDLE -> EXEC: at an edge with req0 or req1 high, the block SHALL:
- select a winner
- capture that requester's a, b and sel into internal registers
- set that requester's gnt for exactly one cycle
- clear the EXEC cycle counter
REQ-015 Arbitration SHALL be round-robin:
- a single requester wins.
- if both request, the requester not granted most recently wins.
- the last-grant pointer updates at grant.
REQ-016 In EXEC the counter SHALL increment each edge. At the edge where counter == EXEC_CYCLES-1 the block SHALL:
- load the winner's rsp_y with the ALU result of the captured operands
- set the winner's rsp_valid
- move to RESP
REQ-017 Arithmetic SHALL be 3 bits wide: add/subtract are zero-extended and modulo 8; logic results have bit 2 = 0.
- 3+3 gives 6.
- 0-1 gives 7.
- 1-3 gives 6.
REQ-018 Latency SHALL be fixed: from the request-sampling edge k, rsp_valid rises at edge k+EXEC_CYCLES.
REQ-019 In RESP, rsp_valid and rsp_y of the winner SHALL hold stable until an edge where the winner's rsp_ack is high. At that edge rsp_valid clears and the state returns to IDLE; a new grant is possible at the following edge.
REQ-020 The non-winning rsp_valid SHALL stay 0 and its rsp_y SHALL hold its previous value.
REQ-021 rsp_ack while the corresponding rsp_valid is low SHALL be ignored, and so SHALL the other requester's ack.
REQ-022 req inputs SHALL be ignored in EXEC and RESP. Operand changes after the grant edge SHALL NOT affect the in-flight result.
REQ-023 A requester still holding req in IDLE after its response completes SHALL be treated as a new request.

Reset
REQ-024 At an edge with rst high, the block SHALL set:
- state = IDLE
- counter = 0
- gnt0 = gnt1 = 0
- rsp_valid0 = rsp_valid1 = 0
- rsp_y0 = rsp_y1 = 000
- busy = 0
- last-grant pointer = requester 1, so requester 0 wins the first tie
REQ-025 Reset SHALL override everything, including mid-EXEC or mid-RESP. Any in-flight operation is discarded with no response.

Verification
REQ-026 Single add, EXEC_CYCLES=1: req0 with a0=3, b0=3, sel0=000 -> gnt0 pulses one cycle, rsp_valid0 high one cycle later with rsp_y0=110, held until rsp_ack0.
REQ-027 Subtract wrap: req1 with a1=0, b1=1, sel1=001 -> rsp_y1=111. Also sel1=101 with a1=2, b1=1 -> rsp_y1=000.
REQ-028 Tie fairness: req0 and req1 held continuously, acks returned immediately -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-029 Held response: rsp_ack0 withheld 5 cycles while req1 is high -> rsp_valid0/rsp_y0 stable, gnt1 = 0, busy = 1. After ack, gnt1 pulses one cycle later.
REQ-030 Reset mid-operation: rst asserted in EXEC (EXEC_CYCLES=3) -> next cycle all outputs are zero, no rsp_valid appears, and a fresh req0 is then granted normally.
REQ-031 Operand isolation: after gnt0, change a0/b0/sel0 and pulse rsp_ack0 early -> result matches the captured operands and the early ack is ignored.
